// File: rtl/byte_mem_arbiter.sv
// byte_mem_arbiter: two-requester round-robin arbiter and access sequencer
// for the 4 x 8-bit latch-based byte memory. Each granted request runs
// SETUP -> (STORE -> HOLD | READ) -> ACK with registered memory-side outputs.
module byte_mem_arbiter #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int STORE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_sel,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STORE, S_HOLD, S_READ, S_ACK
  } state_t;

  localparam int MAX_CYC = (SETUP_CYCLES > STORE_CYCLES) ? SETUP_CYCLES : STORE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_q, gnt_d;          // 0 = requester 0, 1 = requester 1
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   sel_d;
  logic [DATA_W-1:0]   data_d;
  logic                store_d, ack0_d, ack1_d;
  logic [DATA_W-1:0]   rdata0_d, rdata1_d;

  // State, latched request and all outputs are registered; reset aborts at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      mem_sel      <= '0;
      mem_data     <= '0;
      mem_store    <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      mem_sel      <= sel_d;
      mem_data     <= data_d;
      mem_store    <= store_d;
      ack0         <= ack0_d;
      ack1         <= ack1_d;
      rdata0       <= rdata0_d;
      rdata1       <= rdata1_d;
    end
  end

  // Next state: arbitration and request latching in IDLE, timed phase walk after.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    sel_d        = mem_sel;
    data_d       = mem_data;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes next.
          gnt_d        = (req0 && req1) ? ~last_grant_q : req1;
          last_grant_d = gnt_d;
          we_d         = gnt_d ? we1    : we0;
          sel_d        = gnt_d ? addr1  : addr0;
          data_d       = gnt_d ? wdata1 : wdata0;
          state_d      = S_SETUP;
        end
      end
      S_SETUP: if (cnt_q == SETUP_LAST) state_d = we_q ? S_STORE : S_READ;
      S_STORE: if (cnt_q == STORE_LAST) state_d = S_HOLD;
      S_HOLD:  state_d = S_ACK;
      S_READ:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Phase counter restarts on every state change.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Output decode: next-cycle values of the registered outputs.
  always_comb begin
    store_d  = (state_d == S_STORE);
    ack0_d   = (state_d == S_ACK) && !gnt_d;
    ack1_d   = (state_d == S_ACK) &&  gnt_d;
    rdata0_d = (state_q == S_READ && !gnt_q) ? mem_q : rdata0;
    rdata1_d = (state_q == S_READ &&  gnt_q) ? mem_q : rdata1;
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// tb_byte_mem_arbiter: directed bench for byte_mem_arbiter with a behavioural
// model of the 4-byte memory bank hanging off mem_sel/mem_data/mem_store.
module tb_byte_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [1:0] mem_sel;
  logic [7:0] mem_data;
  logic       mem_store;
  logic [7:0] mem_q;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Memory bank model: byte written while store is high, read through the mux.
  logic [7:0] mem [4];
  always @(posedge clk) if (mem_store) mem[mem_sel] <= mem_data;
  assign mem_q = mem[mem_sel];

  always #5 clk = ~clk;

  byte_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_sel(mem_sel), .mem_data(mem_data), .mem_store(mem_store), .mem_q(mem_q),
    .busy(busy)
  );

  // Background watchers: simultaneous acks and sel/data moving during store.
  int         both_ack = 0;
  int         store_move = 0;
  logic       prev_store = 1'b0;
  logic [1:0] prev_sel;
  logic [7:0] prev_data;
  always @(negedge clk) begin
    if (ack0 && ack1) both_ack++;
    if (mem_store && prev_store && (mem_sel != prev_sel || mem_data != prev_data)) store_move++;
    prev_store = mem_store;
    prev_sel   = mem_sel;
    prev_data  = mem_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction started at a negedge with the DUT idle. Bit c of each
  // mask is the value seen in cycle c (cycle 0 = IDLE cycle sampling req).
  // churn: instead of dropping req in cycle 1, scramble addr/wdata and drop
  // req during cycle 2 (STORE).
  task automatic run_txn(input bit who, input bit we, input logic [1:0] addr,
                         input logic [7:0] data, input bit churn,
                         output logic [15:0] st_mask, output logic [15:0] a0_mask,
                         output logic [15:0] a1_mask, output logic [1:0] sel1,
                         output logic [7:0] data1);
    st_mask = '0; a0_mask = '0; a1_mask = '0; sel1 = '0; data1 = '0;
    if (!who) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data; end
    else      begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data; end
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      st_mask[c] = mem_store;
      a0_mask[c] = ack0;
      a1_mask[c] = ack1;
      if (c == 1) begin sel1 = mem_sel; data1 = mem_data; end
      if (!churn && c == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (churn && c == 2) begin
        if (!who) begin addr0 = ~addr; wdata0 = ~data; req0 = 1'b0; end
        else      begin addr1 = ~addr; wdata1 = ~data; req1 = 1'b0; end
      end
    end
  endtask

  logic [15:0] st, a0, a1;
  logic [1:0]  s1;
  logic [7:0]  d1;
  int          order [4];
  int          nack;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    // 1. Reset with inputs churning: all outputs stay at 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = i[0]; req1 = i[1]; we0 = ~i[0]; we1 = i[0];
      addr0 = 2'(i); addr1 = 2'(3 - i); wdata0 = 8'hF0 + 8'(i); wdata1 = 8'h0F;
    end
    @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_store", mem_store, 0);
    check("rst_sel", mem_sel, 0);
    check("rst_data", mem_data, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    reset = 1'b0;
    @(negedge clk);

    // 2. Write0 addr 2 = A5: setup in cycle 1, store cycles 2-3, ack0 cycle 5.
    run_txn(1'b0, 1'b1, 2'd2, 8'hA5, 1'b0, st, a0, a1, s1, d1);
    check("w0_sel_c1", s1, 2);
    check("w0_data_c1", d1, 8'hA5);
    check("w0_store_cycles", st, 16'h000C);
    check("w0_ack0_cycle", a0, 16'h0020);
    check("w0_ack1_none", a1, 16'h0000);
    check("w0_mem2", mem[2], 8'hA5);
    check("w0_idle_busy", busy, 0);

    // 3. Read-back by requester 1: ack1 at cycle 3 with A5, rdata0 untouched.
    run_txn(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, st, a0, a1, s1, d1);
    check("r1_ack1_cycle", a1, 16'h0008);
    check("r1_ack0_none", a0, 16'h0000);
    check("r1_no_store", st, 16'h0000);
    check("r1_rdata1", rdata1, 8'hA5);
    check("r1_rdata0_kept", rdata0, 8'h00);

    // 4. Contention: both held, 0 goes first (last grant was 1), strict alternation.
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 8'h22;
    nack = 0;
    for (int c = 0; c < 60 && nack < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        order[nack] = ack1 ? 1 : 0;
        nack++;
        if (ack0) begin addr0 = 2'd2; wdata0 = 8'h33; end
        if (ack1) begin addr1 = 2'd3; wdata1 = 8'h44; end
        if (nack == 4) begin req0 = 0; req1 = 0; end
      end
    end
    check("cont_ack_count", nack, 4);
    for (int i = 0; i < nack; i++) check($sformatf("cont_order%0d", i), order[i], i % 2);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("cont_mem0", mem[0], 8'h11);
    check("cont_mem1", mem[1], 8'h22);
    check("cont_mem2", mem[2], 8'h33);
    check("cont_mem3", mem[3], 8'h44);
    check("cont_rdata_kept", {rdata0, rdata1}, {8'h00, 8'hA5});

    // 5. Churn during STORE: latched addr 1 / 5A is what lands, single ack0.
    run_txn(1'b0, 1'b1, 2'd1, 8'h5A, 1'b1, st, a0, a1, s1, d1);
    check("churn_store_cycles", st, 16'h000C);
    check("churn_ack0_once", a0, 16'h0020);
    check("churn_mem1", mem[1], 8'h5A);
    check("churn_mem3_kept", mem[3], 8'h44);

    // Read by requester 0 of the churned byte; rdata1 unchanged.
    run_txn(1'b0, 1'b0, 2'd1, 8'h00, 1'b0, st, a0, a1, s1, d1);
    check("r0_ack0_cycle", a0, 16'h0008);
    check("r0_rdata0", rdata0, 8'h5A);
    check("r0_rdata1_kept", rdata1, 8'hA5);

    // 6. Abort: reset in the middle of a STORE cycle.
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'h99;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    check("abort_store_before", mem_store, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_store_async", mem_store, 0);
    check("abort_busy_async", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    a0 = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy) a0[c] = 1'b1;
    end
    check("abort_no_ack_idle", a0, 16'h0000);
    check("abort_rdata_reset", {rdata0, rdata1}, 16'h0000);

    check("never_both_ack", both_ack, 0);
    check("sel_data_stable_in_store", store_move, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
